// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: applies EX-stage branch/JAL/JALR redirects, flushes IF/ID and ID/EX,
// and ignores further redirects for a SHADOW_CYCLES window. Optional counters: BRANCH_PERF_EN.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC      = 32'h0000_0100,
    parameter int          SHADOW_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic        take_branch_i,
    input  logic        jal_i,
    input  logic        jalr_i,
    input  logic [31:0] pc_ex_i,
    input  logic [31:0] imm_ex_i,
    input  logic [31:0] rs1_ex_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic        misalign_o,
`ifdef BRANCH_PERF_EN
    output logic [31:0] br_count_o,
    output logic [31:0] br_taken_o,
`endif
    output logic [31:0] redirect_target_o
);

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } state_t;

    localparam logic [2:0] SHADOW_LOAD = 3'(SHADOW_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target;
    logic        req;
    logic        accept;
    logic        misalign;

`ifdef BRANCH_PERF_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] br_taken_q, br_taken_d;
`endif

    // JALR clears bit 0 of its sum; branch and JAL share the PC-relative adder.
    always_comb begin
        if (jalr_i) begin
            target = (rs1_ex_i + imm_ex_i) & ~32'h1;
        end else begin
            target = pc_ex_i + imm_ex_i;
        end
    end

    assign req      = (branch_i & take_branch_i) | jal_i | jalr_i;
    assign accept   = req & (state_q == RUN);
    assign misalign = accept & target[1];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pc_d    = pc_q + 32'd4;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (misalign) begin
            pc_d = TRAP_VEC;
        end else if (accept) begin
            pc_d = target;
        end else if (stall_i) begin
            pc_d = pc_q;
        end

        // The shadow counter runs through stalls so the window length is fixed in cycles.
        case (state_q)
            RUN: begin
                if (accept) begin
                    state_d = SHADOW;
                    cnt_d   = SHADOW_LOAD;
                end
            end
            SHADOW: begin
                if (cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

`ifdef BRANCH_PERF_EN
    always_comb begin
        br_count_d = br_count_q;
        br_taken_d = br_taken_q;
        if (branch_i && (state_q == RUN) && (br_count_q != 32'hFFFF_FFFF)) begin
            br_count_d = br_count_q + 32'd1;
        end
        // Only a redirect actually caused by the conditional branch counts as taken.
        if (accept && branch_i && take_branch_i && !jal_i && !jalr_i &&
            (br_taken_q != 32'hFFFF_FFFF)) begin
            br_taken_d = br_taken_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            state_q    <= RUN;
            cnt_q      <= 3'd0;
`ifdef BRANCH_PERF_EN
            br_count_q <= 32'd0;
            br_taken_q <= 32'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            pc_q       <= pc_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
`ifdef BRANCH_PERF_EN
            br_count_q <= br_count_d;
            br_taken_q <= br_taken_d;
`endif
        end
    end

    assign pc_o              = pc_q;
    assign pc_plus4_o        = pc_q + 32'd4;
    assign redirect_o        = accept;
    assign flush_o           = accept;
    assign misalign_o        = misalign;
    assign redirect_target_o = target;

`ifdef BRANCH_PERF_EN
    assign br_count_o = br_count_q;
    assign br_taken_o = br_taken_q;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: each driven cycle pushes its expected outputs,
// which are popped and compared mid-cycle, away from the rising edge.
module tb_pc_redirect_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, branch_i, take_branch_i, jal_i, jalr_i;
    logic [31:0] pc_ex_i, imm_ex_i, rs1_ex_i;
    logic [31:0] pc_o, pc_plus4_o, redirect_target_o;
    logic        flush_o, redirect_o, misalign_o;
`ifdef BRANCH_PERF_EN
    logic [31:0] br_count_o, br_taken_o;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        redir;
        logic        mis;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk_i = ~clk_i;

    pc_redirect_unit dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .stall_i           (stall_i),
        .branch_i          (branch_i),
        .take_branch_i     (take_branch_i),
        .jal_i             (jal_i),
        .jalr_i            (jalr_i),
        .pc_ex_i           (pc_ex_i),
        .imm_ex_i          (imm_ex_i),
        .rs1_ex_i          (rs1_ex_i),
        .pc_o              (pc_o),
        .pc_plus4_o        (pc_plus4_o),
        .flush_o           (flush_o),
        .redirect_o        (redirect_o),
        .misalign_o        (misalign_o),
`ifdef BRANCH_PERF_EN
        .br_count_o        (br_count_o),
        .br_taken_o        (br_taken_o),
`endif
        .redirect_target_o (redirect_target_o)
    );

    // Called at posedge+1: drive one cycle, push expectations, compare at negedge, end at posedge+1.
    task automatic step(input string tag, input logic br, input logic tk, input logic jl,
                        input logic jr, input logic st, input logic [31:0] pcx,
                        input logic [31:0] imm, input logic [31:0] rs1,
                        input logic [31:0] e_pc, input logic e_red, input logic e_mis,
                        input logic [31:0] e_tgt);
        exp_t e;
        branch_i = br; take_branch_i = tk; jal_i = jl; jalr_i = jr; stall_i = st;
        pc_ex_i = pcx; imm_ex_i = imm; rs1_ex_i = rs1;
        sb_q.push_back('{tag, e_pc, e_red, e_mis, e_tgt});
        @(negedge clk_i);
        e = sb_q.pop_front();
        total++; if (pc_o !== e.pc) begin bad++; $display("FAIL %s pc_o got=%h exp=%h", e.tag, pc_o, e.pc); end
        total++; if (pc_plus4_o !== e.pc + 32'd4) begin bad++; $display("FAIL %s pc_plus4_o got=%h exp=%h", e.tag, pc_plus4_o, e.pc + 32'd4); end
        total++; if (redirect_o !== e.redir) begin bad++; $display("FAIL %s redirect_o got=%b exp=%b", e.tag, redirect_o, e.redir); end
        total++; if (flush_o !== e.redir) begin bad++; $display("FAIL %s flush_o got=%b exp=%b", e.tag, flush_o, e.redir); end
        total++; if (misalign_o !== e.mis) begin bad++; $display("FAIL %s misalign_o got=%b exp=%b", e.tag, misalign_o, e.mis); end
        total++; if (redirect_target_o !== e.tgt) begin bad++; $display("FAIL %s target got=%h exp=%h", e.tag, redirect_target_o, e.tgt); end
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input string tag, input logic [31:0] e_pc);
        step(tag, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, e_pc, 0, 0, 32'h0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        branch_i = 0; take_branch_i = 0; jal_i = 0; jalr_i = 0; stall_i = 0;
        pc_ex_i = 0; imm_ex_i = 0; rs1_ex_i = 0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        branch_i = 0; take_branch_i = 0; jal_i = 0; jalr_i = 0; stall_i = 0;
        pc_ex_i = 0; imm_ex_i = 0; rs1_ex_i = 0;
        #2;
        total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL reset pc_o got=%h exp=%h", pc_o, 32'h0); end
        total++; if ({flush_o, redirect_o, misalign_o} !== 3'b000) begin bad++; $display("FAIL reset flags got=%b exp=000", {flush_o, redirect_o, misalign_o}); end
`ifdef BRANCH_PERF_EN
        total++; if ({br_count_o, br_taken_o} !== 64'h0) begin bad++; $display("FAIL reset perf got=%h/%h exp=0/0", br_count_o, br_taken_o); end
`endif
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_free_run();
        idle("free0", 32'h0);
        idle("free1", 32'h4);
        idle("free2", 32'h8);
        idle("free3", 32'hC);
    endtask

    task automatic test_branch_shadow();
        step("br_taken", 1, 1, 0, 0, 0, 32'h40, 32'h20, 32'h0, 32'h10, 1, 0, 32'h60);
        step("shadow1", 0, 0, 1, 0, 0, 32'h0, 32'h200, 32'h0, 32'h60, 0, 0, 32'h200);
        step("shadow2", 0, 0, 1, 0, 0, 32'h0, 32'h200, 32'h0, 32'h64, 0, 0, 32'h200);
        step("run_jal", 0, 0, 1, 0, 0, 32'h80, 32'h8, 32'h0, 32'h68, 1, 0, 32'h88);
        idle("jal_sh1", 32'h88);
        idle("jal_sh2", 32'h8C);
    endtask

    task automatic test_misalign();
        step("jalr_mis", 0, 0, 0, 1, 0, 32'h0, 32'h4, 32'h103, 32'h90, 1, 1, 32'h106);
        idle("trap_pc", 32'h100);
        idle("trap_sh2", 32'h104);
        step("jalr_bit0", 0, 0, 0, 1, 0, 32'h0, 32'h10, 32'h201, 32'h108, 1, 0, 32'h210);
        idle("jalr_sh1", 32'h210);
        idle("jalr_sh2", 32'h214);
        idle("jalr_run", 32'h218);
    endtask

    task automatic test_stall();
        do_reset();
        idle("st_pre0", 32'h0);
        idle("st_pre1", 32'h4);
        step("stall1", 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h8, 0, 0, 32'h0);
        step("stall2", 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h8, 0, 0, 32'h0);
        step("stall_jal", 0, 0, 1, 0, 1, 32'h4, 32'h10, 32'h0, 32'h8, 1, 0, 32'h14);
        step("st_sh1", 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h14, 0, 0, 32'h0);
        step("st_sh2", 0, 0, 1, 0, 0, 32'h0, 32'h20, 32'h0, 32'h14, 0, 0, 32'h20);
        step("st_run", 0, 0, 1, 0, 0, 32'h0, 32'h20, 32'h0, 32'h18, 1, 0, 32'h20);
        idle("st_tgt", 32'h20);
    endtask

    task automatic test_not_taken();
        do_reset();
        for (int i = 0; i < 8; i++) idle("nt_pre", 32'(i * 4));
        step("not_taken", 1, 0, 0, 0, 0, 32'h300, 32'h10, 32'h0, 32'h20, 0, 0, 32'h310);
`ifdef BRANCH_PERF_EN
        total++; if (br_count_o !== 32'd1 || br_taken_o !== 32'd0) begin bad++; $display("FAIL perf_nt got=%0d/%0d exp=1/0", br_count_o, br_taken_o); end
`endif
        step("taken_after", 1, 1, 0, 0, 0, 32'h0, 32'h400, 32'h0, 32'h24, 1, 0, 32'h400);
        step("br_in_shadow", 1, 1, 0, 0, 0, 32'h0, 32'h500, 32'h0, 32'h400, 0, 0, 32'h500);
`ifdef BRANCH_PERF_EN
        total++; if (br_count_o !== 32'd2 || br_taken_o !== 32'd1) begin bad++; $display("FAIL perf_tk got=%0d/%0d exp=2/1", br_count_o, br_taken_o); end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        step("ar_jal", 0, 0, 1, 0, 0, 32'h0, 32'h800, 32'h0, 32'h0, 1, 0, 32'h800);
        jal_i = 1'b0;
        #1 rst_i = 1'b1;
        #1;
        total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL async_rst pc_o got=%h exp=%h", pc_o, 32'h0); end
        #1 rst_i = 1'b0;
        @(posedge clk_i); #1;
        step("ar_first", 0, 0, 1, 0, 0, 32'h0, 32'h40, 32'h0, 32'h4, 1, 0, 32'h40);
        idle("ar_tgt", 32'h40);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_branch_shadow();
        test_misalign();
        test_stall();
        test_not_taken();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
